// File: rtl/exu_muldiv_pkg.sv
// Shared RV32M encodings for the execute-stage multiply/divide unit:
// M-extension funct3 codes, the OP opcode/funct7 pair and operand-sign helpers.
package exu_muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic rs1_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// shared accumulator/shift registers, sign fix-up folded into the FIN entry edge.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] source1_i,
  input  logic [XLEN-1:0] source2_i,
  input  logic [REGW-1:0] rd_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [REGW-1:0] rd_addr_o,
  output logic            wb_en_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [REGW-1:0] RD_ZERO  = {REGW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e            state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        funct3_r;
  logic [REGW-1:0]   rd_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic [XLEN-1:0]   acc_r;
  logic [XLEN-1:0]   shr_r;
  logic [XLEN-1:0]   opb_r;

  logic              sa_s, sb_s, div0_s, ovf_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, spec_res_s;
  logic [XLEN:0]     sum_s, rem_sh_s;
  logic [XLEN-1:0]   diff_s, acc_n_s, shr_n_s, res_s;
  logic [2*XLEN-1:0] prod_s;

  // Operand capture: sign flags, magnitudes and the divide-by-zero/overflow bypass results.
  always_comb begin
    sa_s       = rs1_signed(funct3_i) & source1_i[XLEN-1];
    sb_s       = rs2_signed(funct3_i) & source2_i[XLEN-1];
    mag_a_s    = sa_s ? (ZERO - source1_i) : source1_i;
    mag_b_s    = sb_s ? (ZERO - source2_i) : source2_i;
    div0_s     = funct3_i[2] && (source2_i == ZERO);
    ovf_s      = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                 (source1_i == MOST_NEG) && (source2_i == ONES);
    spec_res_s = ZERO;
    if (div0_s) begin
      spec_res_s = funct3_i[1] ? source1_i : ONES;
    end else if (ovf_s) begin
      spec_res_s = funct3_i[1] ? ZERO : source1_i;
    end else begin
      spec_res_s = ZERO;
    end
  end

  // One iteration: shift-add for multiply, restoring subtract for divide; plus final fix-up.
  always_comb begin
    sum_s    = {1'b0, acc_r} + (shr_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    rem_sh_s = {acc_r, shr_r[XLEN-1]};
    diff_s   = rem_sh_s[XLEN-1:0] - opb_r;
    if (funct3_r[2]) begin
      if (rem_sh_s >= {1'b0, opb_r}) begin
        acc_n_s = diff_s;
        shr_n_s = {shr_r[XLEN-2:0], 1'b1};
      end else begin
        acc_n_s = rem_sh_s[XLEN-1:0];
        shr_n_s = {shr_r[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_n_s = sum_s[XLEN:1];
      shr_n_s = {sum_s[0], shr_r[XLEN-1:1]};
    end
    prod_s = neg_q_r ? ({(2*XLEN){1'b0}} - {acc_n_s, shr_n_s}) : {acc_n_s, shr_n_s};
    case (funct3_r)
      F3_MUL:                       res_s = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_s = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              res_s = neg_q_r ? (ZERO - shr_n_s) : shr_n_s;
      F3_REM, F3_REMU:              res_s = neg_r_r ? (ZERO - acc_n_s) : acc_n_s;
      default:                      res_s = ZERO;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      funct3_r  <= 3'b000;
      rd_r      <= RD_ZERO;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      acc_r     <= ZERO;
      shr_r     <= ZERO;
      opb_r     <= ZERO;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      wb_en_o   <= 1'b0;
      result_o  <= ZERO;
      rd_addr_o <= RD_ZERO;
    end else begin
      done_o  <= 1'b0;
      wb_en_o <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_o <= 1'b0;
          if (!flush_i && start_i) begin
            funct3_r <= funct3_i;
            rd_r     <= rd_addr_i;
            neg_q_r  <= sa_s ^ sb_s;
            neg_r_r  <= sa_s;
            acc_r    <= ZERO;
            shr_r    <= mag_a_s;
            opb_r    <= mag_b_s;
            cnt_r    <= {CW{1'b0}};
            busy_o   <= 1'b1;
            if (div0_s || ovf_s) begin
              state_r   <= FIN;
              done_o    <= 1'b1;
              wb_en_o   <= (rd_addr_i != RD_ZERO);
              result_o  <= spec_res_s;
              rd_addr_o <= rd_addr_i;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state_r <= IDLE;
            busy_o  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
          end else begin
            acc_r <= acc_n_s;
            shr_r <= shr_n_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(XLEN - 1)) begin
              state_r   <= FIN;
              done_o    <= 1'b1;
              wb_en_o   <= (rd_r != RD_ZERO);
              result_o  <= res_s;
              rd_addr_o <= rd_r;
            end
          end
        end
        FIN: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
          cnt_r   <= {CW{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed table-driven bench for exu_muldiv plus hand-written flush and reset sequences.
module tb_exu_muldiv;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int NV   = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [2:0]      funct3_i = 3'b000;
  logic [XLEN-1:0] source1_i = 32'h0;
  logic [XLEN-1:0] source2_i = 32'h0;
  logic [REGW-1:0] rd_addr_i = 5'd0;
  logic            busy_o, done_o, wb_en_o;
  logic [XLEN-1:0] result_o;
  logic [REGW-1:0] rd_addr_o;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [NV];

  exu_muldiv #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .source1_i(source1_i), .source2_i(source2_i),
    .rd_addr_i(rd_addr_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_addr_o(rd_addr_o), .wb_en_o(wb_en_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    funct3_i  = f3;
    source1_i = a;
    source2_i = b;
    rd_addr_i = rd;
    start_i   = 1'b1;
  endtask

  // Counts edges from the accept edge (cycle 1) until done_o is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      start_i = 1'b0;
    end while (!done_o && cyc < 200);
  endtask

  task automatic watch_no_done(input string name, input int ncyc);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (done_o) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{"mul_7x-3",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    tbl[1]  = '{"mulhu_ff",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33};
    tbl[2]  = '{"mulh_ff",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33};
    tbl[3]  = '{"mulhsu_ff",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33};
    tbl[4]  = '{"div_-7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33};
    tbl[5]  = '{"rem_-7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33};
    tbl[6]  = '{"div_7/-2",      3'b100, 32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 33};
    tbl[7]  = '{"rem_7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 5'd12, 32'h00000001, 33};
    tbl[8]  = '{"divu_100/7",    3'b101, 32'd100,      32'd7,        5'd13, 32'd14,       33};
    tbl[9]  = '{"remu_100/7",    3'b111, 32'd100,      32'd7,        5'd14, 32'd2,        33};
    tbl[10] = '{"divu_5/0",      3'b101, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1};
    tbl[11] = '{"remu_7/0",      3'b111, 32'd7,        32'd0,        5'd16, 32'd7,        1};
    tbl[12] = '{"rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, 1};
    tbl[13] = '{"div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1};
    tbl[14] = '{"mul_rd0",       3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       33};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy_o),    32'd0);
    check("rst_done",   32'(done_o),    32'd0);
    check("rst_wb",     32'(wb_en_o),   32'd0);
    check("rst_result", result_o,       32'd0);
    check("rst_rd",     32'(rd_addr_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd);
      wait_done(cyc);
      check({tbl[i].name, "/done"},   32'(done_o),    32'd1);
      check({tbl[i].name, "/lat"},    32'(cyc),       32'(tbl[i].lat));
      check({tbl[i].name, "/result"}, result_o,       tbl[i].exp);
      check({tbl[i].name, "/rd"},     32'(rd_addr_o), 32'(tbl[i].rd));
      check({tbl[i].name, "/wb_en"},  32'(wb_en_o),   32'(tbl[i].rd != 5'd0));
      @(posedge clk);
      #1;
      check({tbl[i].name, "/done_pulse"}, 32'(done_o), 32'd0);
      check({tbl[i].name, "/idle"},       32'(busy_o), 32'd0);
      check({tbl[i].name, "/hold"},       result_o,    tbl[i].exp);
    end

    // Flush at CALC cycle 10: unit drops busy, never completes, keeps prior result.
    issue(3'b000, 32'd3, 32'd5, 5'd7);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("flush/busy_calc", 32'(busy_o), 32'd1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush/busy", 32'(busy_o),    32'd0);
    check("flush/done", 32'(done_o),    32'd0);
    check("flush/keep", result_o,       32'd12);
    check("flush/rd",   32'(rd_addr_o), 32'd0);
    watch_no_done("flush/no_done", 40);
    issue(3'b101, 32'd100, 32'd7, 5'd21);
    wait_done(cyc);
    check("after_flush/lat",    32'(cyc), 32'd33);
    check("after_flush/result", result_o, 32'd14);

    // Flush and start together in IDLE: request must be dropped.
    @(posedge clk);
    #1;
    issue(3'b000, 32'd2, 32'd2, 5'd4);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_start/busy", 32'(busy_o), 32'd0);
    watch_no_done("flush_start/no_done", 40);

    // Asynchronous reset mid-CALC, between clock edges.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst/busy",   32'(busy_o),    32'd0);
    check("arst/done",   32'(done_o),    32'd0);
    check("arst/wb",     32'(wb_en_o),   32'd0);
    check("arst/result", result_o,       32'd0);
    check("arst/rd",     32'(rd_addr_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    watch_no_done("arst/no_done", 40);
    issue(3'b000, 32'd6, 32'd7, 5'd3);
    wait_done(cyc);
    check("after_rst/lat",    32'(cyc), 32'd33);
    check("after_rst/result", result_o, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
EXU_MULDIV -- requirements
Module: exu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (even, >=8).
REQ-002 SHALL have parameter REGW, default 5, meaning register-address width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, meaning issue request from ID/EX.
REQ-006 SHALL have port flush_i, input, 1, meaning kill from CU, e.g. a taken jump.
REQ-007 SHALL have port funct3_i, input, 3, meaning the operation code:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-008 SHALL have port source1_i, input, XLEN, meaning rs1 value (multiplicand/dividend).
REQ-009 SHALL have port source2_i, input, XLEN, meaning rs2 value (multiplier/divisor).
REQ-010 SHALL have port rd_addr_i, input, REGW, meaning destination register.
REQ-011 SHALL have port busy_o, output, 1, meaning the unit is occupied and CU must stall issue.
REQ-012 SHALL have port done_o, output, 1, meaning a one-cycle result-valid pulse.
REQ-013 SHALL have port result_o, output, XLEN, meaning the result, held until the next done_o.
REQ-014 SHALL have port rd_addr_o, output, REGW, meaning the captured destination.
REQ-015 SHALL have port wb_en_o, output, 1, equal to done_o AND (rd_addr_o != 0).

Function
REQ-016 SHALL implement the states IDLE, CALC and FIN; busy_o SHALL be 1 whenever the state is not IDLE.
REQ-017 SHALL accept start_i only in IDLE; it SHALL capture funct3, rd and operand magnitudes and set the sign flags.
REQ-018 SHALL ignore start_i while busy_o=1; CU guarantees the request is held or re-issued.
REQ-019 SHALL, for a normal operation, go IDLE->CALC and run exactly XLEN CALC cycles, then FIN for 1 cycle, then IDLE.
REQ-020 SHALL assert done_o in FIN only, i.e. on cycle XLEN+1 after the accept edge.
REQ-021 SHALL compute multiply as a 2*XLEN unsigned shift-add on magnitudes, one bit per cycle.
REQ-022 SHALL negate the product in FIN when signs differ (MUL/MULH: both operands signed; MULHSU: rs1 only).
REQ-023 SHALL return product[XLEN-1:0] for MUL and product[2XLEN-1:XLEN] for MULH/MULHSU/MULHU.
REQ-024 SHALL compute divide as restoring division on magnitudes, one quotient bit per cycle.
REQ-025 SHALL apply divide sign fix-up as follows: quotient negated if signs differ (DIV); remainder takes the dividend's sign (REM).
REQ-026 SHALL, for divisor==0, skip CALC and go IDLE->FIN, with done_o 1 cycle after accept:
- DIV/DIVU return all-ones
- REM/REMU return source1_i
REQ-027 SHALL, for signed overflow (source1=most-negative, source2=-1, DIV/REM), skip CALC: DIV returns source1_i, REM returns 0, latency 1 cycle.
REQ-028 SHALL, on flush_i=1 in any state, go to IDLE next edge with no done_o; result_o and rd_addr_o keep their last values.
REQ-029 SHALL give flush_i priority when start_i and flush_i are both high in IDLE: the request is not accepted.
REQ-030 SHALL update result_o and rd_addr_o only on the edge entering FIN.
REQ-031 SHALL keep the iteration counter at ceil(log2(XLEN+1)) bits, with no wrap inside CALC.

Reset
REQ-032 SHALL, on rst=1 and independent of clk, force IDLE, counter 0, busy_o=0, done_o=0, wb_en_o=0, result_o=0, rd_addr_o=0, and clear all internal registers.
REQ-033 SHALL, on reset mid-CALC, discard the operation and produce no done_o after release.

Structure
REQ-034 SHALL place the eight M-extension funct3 codes and opcode 0110011/funct7 0000001 in the shared riscv_define.v.
REQ-035 SHALL keep the state encoding local to the module.
REQ-036 SHALL be implemented as a single module with shared accumulator/shift registers for mul and div; a sub-module is not warranted.

Verification
REQ-037 Bench SHALL cover MUL 7*(-3), start held 1 cycle -> done at cycle 33, result 0xFFFFFFEB, wb_en=1 for rd=5.
REQ-038 Bench SHALL cover MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-039 Bench SHALL cover DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; both at cycle 33.
REQ-040 Bench SHALL cover DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REM 0x80000000/-1 -> 0 at cycle 1; DIV same operands -> 0x80000000.
REQ-041 Bench SHALL cover flush_i at CALC cycle 10 -> busy_o low next cycle, no done_o, prior result_o unchanged; a new start is then accepted normally.
REQ-042 Bench SHALL cover rst asserted mid-CALC between clock edges -> outputs 0 immediately, no done_o after release; rd=0 operation -> done_o=1, wb_en_o=0.
